// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Second stage of the 5-stage RV32I pipeline, directly downstream of fetch.
// Holds the 32x32 architectural register file (written from writeback),
// decodes the fetched instruction into an immediate and a control bundle,
// detects load-use hazards and drives the D pipeline register for execute.
//
// Ports:
//   clk, rst                 clock (posedge) and asynchronous active-low reset
//   pc_F, instr_F, valid_F   fetch pipeline register
//   flush_E                  execute is redirecting the PC; squash decode
//   ex_mem_read, ex_rd       load currently in execute (load-use detection)
//   wb_en, wb_rd, wb_data    register-file write port from writeback
//   stall_F                  hold PC and fetch register this cycle
//   *_D                      D pipeline register: valid, PC, operands,
//                            immediate, register indices, funct3, ALU op
//                            and control bits, illegal-opcode flag
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN = 32,
    parameter int ILEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_F,
    input  logic [ILEN-1:0] instr_F,
    input  logic            valid_F,
    input  logic            flush_E,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall_F,
    output logic            valid_D,
    output logic [XLEN-1:0] pc_D,
    output logic [XLEN-1:0] rd1_D,
    output logic [XLEN-1:0] rd2_D,
    output logic [XLEN-1:0] imm_D,
    output logic [4:0]      rs1_D,
    output logic [4:0]      rs2_D,
    output logic [4:0]      rd_D,
    output logic [2:0]      funct3_D,
    output logic [3:0]      alu_op_D,
    output logic            alu_src_D,
    output logic            reg_write_D,
    output logic            mem_read_D,
    output logic            mem_write_D,
    output logic            branch_D,
    output logic            jump_D,
    output logic [1:0]      wb_sel_D,
    output logic            illegal_D
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    // Everything the D register carries, kept together so a bubble or a
    // reset is a single assignment of zero.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [3:0]      alu_op;
        logic            alu_src;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic [1:0]      wb_sel;
        logic            illegal;
    } d_bundle_t;

    logic [XLEN-1:0] rf [NREG];

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] imm;
    imm_fmt_t        imm_fmt;
    logic [3:0]      alu_op;
    logic            alu_src, reg_write, mem_read, mem_write, branch, jump;
    logic [1:0]      wb_sel;
    logic            illegal;
    logic            uses_rs1, uses_rs2;
    logic            hazard;
    d_bundle_t       dec;
    d_bundle_t       d_q;

    assign opcode = instr_F[6:0];
    assign rd     = instr_F[11:7];
    assign funct3 = instr_F[14:12];
    assign rs1    = instr_F[19:15];
    assign rs2    = instr_F[24:20];

    // Reads are combinational. x0 is hardwired to zero, and a writeback to
    // the register being read this cycle is forwarded so decode never sees
    // the stale value.
    assign rd1 = (rs1 == 5'd0)               ? '0      :
                 (wb_en && (wb_rd == rs1))   ? wb_data : rf[rs1];
    assign rd2 = (rs2 == 5'd0)               ? '0      :
                 (wb_en && (wb_rd == rs2))   ? wb_data : rf[rs2];

    // All five RV32I immediate shapes; each is sign-extended from bit 31.
    assign imm_i = XLEN'($signed(instr_F[31:20]));
    assign imm_s = XLEN'($signed({instr_F[31:25], instr_F[11:7]}));
    assign imm_b = XLEN'($signed({instr_F[31], instr_F[7], instr_F[30:25],
                                  instr_F[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({instr_F[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({instr_F[31], instr_F[19:12], instr_F[20],
                                  instr_F[30:21], 1'b0}));

    // Opcode decode into the control bundle. Loads, stores and JALR also
    // select the immediate as ALU operand B because execute forms their
    // address as rs1 + imm; branches compare rs1 against rs2 instead.
    always_comb begin
        imm_fmt   = IMM_NONE;
        alu_op    = 4'b0000;
        alu_src   = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        wb_sel    = 2'b00;
        illegal   = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                imm_fmt   = IMM_U;
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            OPC_JAL: begin
                imm_fmt   = IMM_J;
                jump      = 1'b1;
                reg_write = 1'b1;
                wb_sel    = 2'b10;
            end
            OPC_JALR: begin
                imm_fmt   = IMM_I;
                jump      = 1'b1;
                alu_src   = 1'b1;
                reg_write = 1'b1;
                wb_sel    = 2'b10;
                uses_rs1  = 1'b1;
            end
            OPC_BRANCH: begin
                imm_fmt   = IMM_B;
                branch    = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OPC_LOAD: begin
                imm_fmt   = IMM_I;
                alu_src   = 1'b1;
                mem_read  = 1'b1;
                reg_write = 1'b1;
                wb_sel    = 2'b01;
                uses_rs1  = 1'b1;
            end
            OPC_STORE: begin
                imm_fmt   = IMM_S;
                alu_src   = 1'b1;
                mem_write = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OPC_OPIMM: begin
                imm_fmt   = IMM_I;
                alu_src   = 1'b1;
                reg_write = 1'b1;
                uses_rs1  = 1'b1;
                // instr[30] only distinguishes SRAI from SRLI; for every
                // other OP-IMM it is part of the immediate.
                alu_op    = {(funct3 == 3'b101) ? instr_F[30] : 1'b0, funct3};
            end
            OPC_OP: begin
                reg_write = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                alu_op    = {instr_F[30], funct3};
            end
            default: begin
                illegal   = 1'b1;
            end
        endcase
    end

    // Immediate select by format; R-type and unknown opcodes give zero.
    always_comb begin
        imm = '0;
        case (imm_fmt)
            IMM_I:   imm = imm_i;
            IMM_S:   imm = imm_s;
            IMM_B:   imm = imm_b;
            IMM_U:   imm = imm_u;
            IMM_J:   imm = imm_j;
            default: imm = '0;
        endcase
    end

    // A load in execute produces its value too late for the instruction
    // now in decode; hold fetch for one cycle. A flush wins because the
    // instruction being stalled is about to be discarded anyway.
    assign hazard  = valid_F && ex_mem_read && (ex_rd != 5'd0) &&
                     ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
    assign stall_F = hazard && !flush_E;

    // Candidate D register contents. Data fields follow the decode even
    // when fetch is empty; control bits only survive with a real instruction.
    always_comb begin
        dec           = '0;
        dec.valid     = valid_F;
        dec.pc        = pc_F;
        dec.rd1       = rd1;
        dec.rd2       = rd2;
        dec.imm       = imm;
        dec.rs1       = rs1;
        dec.rs2       = rs2;
        dec.rd        = rd;
        dec.funct3    = funct3;
        dec.alu_op    = alu_op;
        dec.alu_src   = alu_src   && valid_F;
        dec.reg_write = reg_write && valid_F;
        dec.mem_read  = mem_read  && valid_F;
        dec.mem_write = mem_write && valid_F;
        dec.branch    = branch    && valid_F;
        dec.jump      = jump      && valid_F;
        dec.wb_sel    = valid_F ? wb_sel : 2'b00;
        dec.illegal   = illegal   && valid_F;
    end

    // Register file. Writes to x0 are dropped so that entry stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            rf[wb_rd] <= wb_data;
        end
    end

    // D pipeline register. Flush and load-use both insert an all-zero
    // bubble; on a load-use stall fetch holds, so the same instruction is
    // decoded again next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_q <= '0;
        end else if (flush_E || hazard) begin
            d_q <= '0;
        end else begin
            d_q <= dec;
        end
    end

    assign valid_D     = d_q.valid;
    assign pc_D        = d_q.pc;
    assign rd1_D       = d_q.rd1;
    assign rd2_D       = d_q.rd2;
    assign imm_D       = d_q.imm;
    assign rs1_D       = d_q.rs1;
    assign rs2_D       = d_q.rs2;
    assign rd_D        = d_q.rd;
    assign funct3_D    = d_q.funct3;
    assign alu_op_D    = d_q.alu_op;
    assign alu_src_D   = d_q.alu_src;
    assign reg_write_D = d_q.reg_write;
    assign mem_read_D  = d_q.mem_read;
    assign mem_write_D = d_q.mem_write;
    assign branch_D    = d_q.branch;
    assign jump_D      = d_q.jump;
    assign wb_sel_D    = d_q.wb_sel;
    assign illegal_D   = d_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Self-checking bench for decode_stage. A reference model of the decode
// stage (register array, instruction classes, immediate formats) predicts
// the D register every cycle and a compare process checks every output on
// each falling edge. Directed vectors add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic [1:0]  wb_sel;
        logic        illegal;
    } exp_t;

    localparam int C_NONE   = -1;
    localparam int C_LUI    = 0;
    localparam int C_AUIPC  = 1;
    localparam int C_JAL    = 2;
    localparam int C_JALR   = 3;
    localparam int C_BRANCH = 4;
    localparam int C_LOAD   = 5;
    localparam int C_STORE  = 6;
    localparam int C_OPIMM  = 7;
    localparam int C_OP     = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_F = '0;
    logic [31:0] instr_F = '0;
    logic        valid_F = 1'b0;
    logic        flush_E = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;

    logic        stall_F, valid_D;
    logic [31:0] pc_D, rd1_D, rd2_D, imm_D;
    logic [4:0]  rs1_D, rs2_D, rd_D;
    logic [2:0]  funct3_D;
    logic [3:0]  alu_op_D;
    logic        alu_src_D, reg_write_D, mem_read_D, mem_write_D;
    logic        branch_D, jump_D, illegal_D;
    logic [1:0]  wb_sel_D;

    int          tests_run = 0;
    int          tests_failed = 0;

    logic [31:0] mregs [32];
    exp_t        exp_d = '0;

    decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pc_F        (pc_F),
        .instr_F     (instr_F),
        .valid_F     (valid_F),
        .flush_E     (flush_E),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .stall_F     (stall_F),
        .valid_D     (valid_D),
        .pc_D        (pc_D),
        .rd1_D       (rd1_D),
        .rd2_D       (rd2_D),
        .imm_D       (imm_D),
        .rs1_D       (rs1_D),
        .rs2_D       (rs2_D),
        .rd_D        (rd_D),
        .funct3_D    (funct3_D),
        .alu_op_D    (alu_op_D),
        .alu_src_D   (alu_src_D),
        .reg_write_D (reg_write_D),
        .mem_read_D  (mem_read_D),
        .mem_write_D (mem_write_D),
        .branch_D    (branch_D),
        .jump_D      (jump_D),
        .wb_sel_D    (wb_sel_D),
        .illegal_D   (illegal_D)
    );

    always #5 clk = ~clk;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, act, expv, $time);
        end
    endtask

    // Fetch register contents for the next cycle.
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] ins,
                                 input logic vld);
        pc_F    = pc;
        instr_F = ins;
        valid_F = vld;
    endtask

    // Advance one clock; returns just after the falling edge so inputs
    // change well away from the capturing edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic int classify(input logic [6:0] opc);
        case (opc)
            7'h37:   return C_LUI;
            7'h17:   return C_AUIPC;
            7'h6F:   return C_JAL;
            7'h67:   return C_JALR;
            7'h63:   return C_BRANCH;
            7'h03:   return C_LOAD;
            7'h23:   return C_STORE;
            7'h13:   return C_OPIMM;
            7'h33:   return C_OP;
            default: return C_NONE;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_en && wb_rd == idx) return wb_data;
        return mregs[idx];
    endfunction

    function automatic logic model_hazard();
        int   cls;
        logic u1, u2;
        cls = classify(instr_F[6:0]);
        u1  = (cls != C_NONE) && !(cls inside {C_LUI, C_AUIPC, C_JAL});
        u2  = cls inside {C_BRANCH, C_STORE, C_OP};
        return valid_F && ex_mem_read && ex_rd != 5'd0 &&
               ((u1 && instr_F[19:15] == ex_rd) || (u2 && instr_F[24:20] == ex_rd));
    endfunction

    // What the D register must hold if the current fetch entry is accepted.
    function automatic exp_t model_decode();
        exp_t        e;
        int          cls;
        logic [31:0] ins;
        ins      = instr_F;
        cls      = classify(ins[6:0]);
        e        = '0;
        e.pc     = pc_F;
        e.rs1    = ins[19:15];
        e.rs2    = ins[24:20];
        e.rd     = ins[11:7];
        e.f3     = ins[14:12];
        e.rd1    = model_read(e.rs1);
        e.rd2    = model_read(e.rs2);
        if (cls inside {C_JALR, C_LOAD, C_OPIMM})
            e.imm = {{20{ins[31]}}, ins[31:20]};
        else if (cls == C_STORE)
            e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        else if (cls == C_BRANCH)
            e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        else if (cls inside {C_LUI, C_AUIPC})
            e.imm = {ins[31:12], 12'h000};
        else if (cls == C_JAL)
            e.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        if (cls == C_OP)
            e.alu_op = {ins[30], e.f3};
        else if (cls == C_OPIMM)
            e.alu_op = {(e.f3 == 3'd5) ? ins[30] : 1'b0, e.f3};
        if (valid_F) begin
            e.valid = 1'b1;
            if (cls == C_NONE) begin
                e.illegal = 1'b1;
            end else begin
                e.reg_write = cls inside {C_LUI, C_AUIPC, C_JAL, C_JALR, C_LOAD, C_OPIMM, C_OP};
                e.alu_src   = cls inside {C_LUI, C_AUIPC, C_JALR, C_LOAD, C_STORE, C_OPIMM};
                e.mem_read  = (cls == C_LOAD);
                e.mem_write = (cls == C_STORE);
                e.branch    = (cls == C_BRANCH);
                e.jump      = cls inside {C_JAL, C_JALR};
                e.wb_sel    = (cls inside {C_JAL, C_JALR}) ? 2'd2 :
                              (cls == C_LOAD) ? 2'd1 : 2'd0;
            end
        end
        return e;
    endfunction

    // Reference model of the stage: reset clears everything at once; on
    // each rising edge either a bubble or the decoded instruction is taken,
    // then the writeback lands in the register array.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_d = '0;
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        end else begin
            if (flush_E || model_hazard()) exp_d = '0;
            else exp_d = model_decode();
            if (wb_en && wb_rd != 5'd0) mregs[wb_rd] = wb_data;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        checkOutput("stall_F",     stall_F,     model_hazard() && !flush_E);
        checkOutput("valid_D",     valid_D,     exp_d.valid);
        checkOutput("pc_D",        pc_D,        exp_d.pc);
        checkOutput("rd1_D",       rd1_D,       exp_d.rd1);
        checkOutput("rd2_D",       rd2_D,       exp_d.rd2);
        checkOutput("imm_D",       imm_D,       exp_d.imm);
        checkOutput("rs1_D",       rs1_D,       exp_d.rs1);
        checkOutput("rs2_D",       rs2_D,       exp_d.rs2);
        checkOutput("rd_D",        rd_D,        exp_d.rd);
        checkOutput("funct3_D",    funct3_D,    exp_d.f3);
        checkOutput("alu_op_D",    alu_op_D,    exp_d.alu_op);
        checkOutput("alu_src_D",   alu_src_D,   exp_d.alu_src);
        checkOutput("reg_write_D", reg_write_D, exp_d.reg_write);
        checkOutput("mem_read_D",  mem_read_D,  exp_d.mem_read);
        checkOutput("mem_write_D", mem_write_D, exp_d.mem_write);
        checkOutput("branch_D",    branch_D,    exp_d.branch);
        checkOutput("jump_D",      jump_D,      exp_d.jump);
        checkOutput("wb_sel_D",    wb_sel_D,    exp_d.wb_sel);
        checkOutput("illegal_D",   illegal_D,   exp_d.illegal);
    end

    // Safety net so the run always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed vectors with hand-computed expectations.
    initial begin
        step();
        step();
        checkOutput("reset_valid", valid_D, 32'd0);
        checkOutput("reset_rd1", rd1_D, 32'd0);
        rst = 1'b1;

        // x5 = 0x1234, then addi x6,x5,1
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_1234;
        applyStimulus(32'h100, 32'h0000_0013, 1'b1);
        step();
        wb_en = 1'b0;
        applyStimulus(32'h104, 32'h0012_8313, 1'b1);
        step();
        checkOutput("addi_rd1", rd1_D, 32'h0000_1234);
        checkOutput("addi_imm", imm_D, 32'h1);
        checkOutput("addi_alu_src", alu_src_D, 32'h1);
        checkOutput("addi_rd", rd_D, 32'd6);
        checkOutput("addi_reg_write", reg_write_D, 32'h1);
        checkOutput("addi_valid", valid_D, 32'h1);

        // same-cycle bypass: add x8,x7,x0 while x7 <= 0xDEADBEEF
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF;
        applyStimulus(32'h108, 32'h0003_8433, 1'b1);
        step();
        checkOutput("bypass_rd1", rd1_D, 32'hDEAD_BEEF);

        // write 0xFF to x0, then read x0 both during and after the write
        wb_rd = 5'd0; wb_data = 32'h0000_00FF;
        applyStimulus(32'h10C, 32'h0000_0433, 1'b1);
        step();
        checkOutput("x0_bypass_rd1", rd1_D, 32'd0);
        wb_en = 1'b0;
        step();
        checkOutput("x0_read_rd1", rd1_D, 32'd0);

        // load-use on rs1: add x6,x5,x1 behind a load to x5
        applyStimulus(32'h110, 32'h0012_8333, 1'b1);
        ex_mem_read = 1'b1; ex_rd = 5'd5;
        #1;
        checkOutput("loaduse_stall", stall_F, 32'h1);
        step();
        checkOutput("loaduse_bubble_valid", valid_D, 32'h0);
        checkOutput("loaduse_bubble_rw", reg_write_D, 32'h0);
        ex_mem_read = 1'b0;
        #1;
        checkOutput("loaduse_release", stall_F, 32'h0);
        step();
        checkOutput("loaduse_add_valid", valid_D, 32'h1);
        checkOutput("loaduse_add_rd", rd_D, 32'd6);
        checkOutput("loaduse_add_rd1", rd1_D, 32'h0000_1234);

        // ex_rd = 0 never stalls; rs2 match does
        ex_mem_read = 1'b1; ex_rd = 5'd0;
        #1;
        checkOutput("loaduse_x0_nostall", stall_F, 32'h0);
        ex_rd = 5'd1;
        #1;
        checkOutput("loaduse_rs2_stall", stall_F, 32'h1);

        // flush beats the hazard
        ex_rd = 5'd5; flush_E = 1'b1;
        #1;
        checkOutput("flush_nostall", stall_F, 32'h0);
        step();
        checkOutput("flush_valid", valid_D, 32'h0);
        flush_E = 1'b0; ex_mem_read = 1'b0;

        // immediates
        applyStimulus(32'h114, 32'hFE00_0CE3, 1'b1);
        step();
        checkOutput("beq_imm", imm_D, 32'hFFFF_FFF8);
        checkOutput("beq_branch", branch_D, 32'h1);
        applyStimulus(32'h118, 32'hABCD_E0B7, 1'b1);
        step();
        checkOutput("lui_imm", imm_D, 32'hABCD_E000);
        applyStimulus(32'h11C, 32'h0010_00EF, 1'b1);
        step();
        checkOutput("jal_imm", imm_D, 32'h0000_0800);
        checkOutput("jal_wb_sel", wb_sel_D, 32'h2);
        applyStimulus(32'h120, 32'hFE21_AE23, 1'b1);
        step();
        checkOutput("sw_imm", imm_D, 32'hFFFF_FFFC);
        checkOutput("sw_mem_write", mem_write_D, 32'h1);

        // illegal opcode
        applyStimulus(32'h124, 32'h0000_007F, 1'b1);
        step();
        checkOutput("illegal_flag", illegal_D, 32'h1);
        checkOutput("illegal_rw", reg_write_D, 32'h0);
        checkOutput("illegal_mw", mem_write_D, 32'h0);

        // empty fetch register: decoded but not valid
        applyStimulus(32'h128, 32'h0012_8313, 1'b0);
        step();
        checkOutput("nofetch_valid", valid_D, 32'h0);
        checkOutput("nofetch_rw", reg_write_D, 32'h0);

        // asynchronous reset in the middle of a cycle
        applyStimulus(32'h12C, 32'hABCD_E0B7, 1'b1);
        step();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_valid", valid_D, 32'h0);
        checkOutput("async_rst_imm", imm_D, 32'h0);
        checkOutput("async_rst_pc", pc_D, 32'h0);
        checkOutput("async_rst_rw", reg_write_D, 32'h0);
        step();
        rst = 1'b1;
        applyStimulus(32'h130, 32'h0012_8313, 1'b1);
        step();
        checkOutput("post_rst_x5", rd1_D, 32'h0);
        checkOutput("post_rst_valid", valid_D, 32'h1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second stage of the 5-stage RV32I pipeline, directly downstream of fetch.
- Consumes the fetch pipeline register (PC, instruction) and holds the 32x32 architectural register file, written from writeback.
- Generates the immediate and control bundle, detects load-use hazards, and drives the D pipeline register consumed by execute.
- Handles stall (hold fetch, insert bubble) and flush (taken branch or jump resolved in execute).

Parameters:
XLEN, 32, datapath and register width
ILEN, 32, instruction width
NREG, 32, architectural register count (x0 hardwired to 0)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous reset, active-low
pc_F  input  XLEN  PC from fetch register
instr_F  input  ILEN  instruction from fetch register
valid_F  input  1  fetch register holds a real instruction
flush_E  input  1  execute redirecting the PC (taken branch or jump)
ex_mem_read  input  1  instruction currently in execute is a load
ex_rd  input  5  destination register of the instruction in execute
wb_en  input  1  writeback register-file write enable
wb_rd  input  5  writeback destination register
wb_data  input  XLEN  writeback data
stall_F  output  1  hold PC and fetch register this cycle
valid_D  output  1  D register holds a real instruction
pc_D  output  XLEN  PC of the decoded instruction
rd1_D, rd2_D  output  XLEN  source operand values
imm_D  output  XLEN  sign-extended immediate
rs1_D, rs2_D, rd_D  output  5  register indices (for forwarding)
funct3_D  output  3  funct3, used for branch and load/store size
alu_op_D  output  4  {funct7[5] qualifier, funct3}
alu_src_D  output  1  1 = ALU operand B is imm_D
reg_write_D, mem_read_D, mem_write_D, branch_D, jump_D  output  1  control bits
wb_sel_D  output  2  00 ALU, 01 memory, 10 PC+4
illegal_D  output  1  unrecognised opcode

Behaviour:
- Reset (rst low, asynchronous): every register-file entry = 0; every D output = 0, including valid_D = 0. Release is synchronous to the next posedge.
- Latency: 1 cycle. A fetch-register value present at edge N appears on the D outputs after edge N.
- Register file reads: combinational.
  - x0 always reads 0.
  - Write-through bypass: if wb_en and wb_rd == rs and rs != 0, the read returns wb_data in the same cycle.
- Register file writes: on posedge when wb_en and wb_rd != 0. Writes to x0 are ignored.
- Opcode decode:
  - LUI 0110111: U-type, rd write, wb ALU, alu_src 1.
  - AUIPC 0010111: U-type, rd write, wb ALU, alu_src 1.
  - JAL 1101111: J-type, jump, wb PC+4.
  - JALR 1100111: I-type, jump, wb PC+4.
  - BRANCH 1100011: B-type, branch, no rd write.
  - LOAD 0000011: I-type, mem_read, wb mem.
  - STORE 0100011: S-type, mem_write, no rd write.
  - OP-IMM 0010011: I-type, alu_src 1.
  - OP 0110011: R-type, alu_src 0.
- Any other opcode: illegal_D = 1, all control bits 0, valid_D follows normal rules.
- alu_op_D:
  - OP: {instr[30], funct3}.
  - OP-IMM: {instr[30] only when funct3 == 101, else 0, funct3}.
  - All other classes: 0000 (add).
- Immediates: I/S/B/U/J formats per RV32I. B and J have bit 0 = 0. U has bits[11:0] = 0. All sign-extended from instr[31].
- Register usage:
  - rs1 is used by every class except LUI, AUIPC and JAL.
  - rs2 is used by BRANCH, STORE and OP only.
- Load-use hazard: hazard = valid_F & ex_mem_read & ex_rd != 0 & ((uses_rs1 & rs1 == ex_rd) | (uses_rs2 & rs2 == ex_rd)).
- stall_F = hazard & !flush_E (combinational).
- D register update each posedge, in priority order:
  - flush_E: bubble.
  - hazard: bubble; fetch holds, so the same instruction is re-decoded next cycle.
  - otherwise: load the decoded fields, with valid_D = valid_F.
- Bubble: valid_D = 0 and all control bits 0. Data fields are don't-care but are driven to 0.
- valid_F = 0: decode still runs, but valid_D = 0 and control bits are forced to 0.
- Simultaneous writeback and decode of the same register: the bypass guarantees the new value.
- Reset mid-stall or mid-flush: reset dominates all other conditions.

Test Plan:
- Reset, then wb x5 = 0x1234 followed by `addi x6,x5,1` (0x00128313) -> next cycle: rd1_D = 0x1234, imm_D = 1, alu_src_D = 1, rd_D = 6, reg_write_D = 1, valid_D = 1.
- Same-cycle bypass: wb_en = 1, wb_rd = 7, wb_data = 0xDEADBEEF while decoding `add x8,x7,x0` -> rd1_D = 0xDEADBEEF. A write to x0 of 0xFF then a read of x0 -> rd1_D = 0.
- Load-use: ex_mem_read = 1, ex_rd = 5, decoding `add x6,x5,x1` -> stall_F = 1 and the next valid_D = 0. Drop ex_mem_read the next cycle -> the add appears with valid_D = 1. With ex_rd = 0 -> no stall.
- Flush priority: a hazard and flush_E = 1 in the same cycle -> stall_F = 0 and the next valid_D = 0.
- Immediates:
  - `beq` with offset -8 (0xFE000CE3) -> imm_D = 0xFFFFFFF8, branch_D = 1.
  - `lui x1,0xABCDE` -> imm_D = 0xABCDE000.
  - `jal` +2048 -> imm_D = 0x00000800, wb_sel_D = 10.
  - `sw` offset -4 -> imm_D = 0xFFFFFFFC.
- Illegal opcode 0x0000007F -> illegal_D = 1, reg_write_D = mem_write_D = 0. Assert rst low mid-stream -> every output is 0 immediately, without waiting for a clock edge.
